video_pos_adj: RTL and testbench
================================

VIDEO_POS_ADJ -- requirements
Module: video_pos_adj

Interface
REQ-001 The block SHALL declare these parameters (name, default, meaning): HW, 9, horizontal tick counter width; VW, 9, line counter width.
REQ-002 The block SHALL have these ports: clk, input, 1, system clock; the block runs on one clock.
REQ-003 reset, input, 1, synchronous active-high reset.
REQ-004 ce_pix, input, 1, pixel clock enable; all state advances only on cycles where ce_pix=1.
REQ-005 hshift, input, 4, signed horizontal picture offset (-8..+7); positive moves the picture right.
REQ-006 vshift, input, 4, signed vertical picture offset (-8..+7); positive moves the picture down.
REQ-007 rgb_in, input, 12, pixel colour {b,g,r}.
REQ-008 hblank_in / vblank_in / hsync_in / vsync_in, input, 1 each, active-high timing from the video timing generator.
REQ-009 rgb_out, output, 12; hblank_out, vblank_out, hsync_out, vsync_out, output, 1 each, active-high.

Function
REQ-010 rgb_out, hblank_out and vblank_out SHALL equal the corresponding inputs delayed by exactly one ce_pix tick.
REQ-011 The tick counter hcnt SHALL increment each ce_pix tick and clear to 0 on the tick where hblank_in rises (0->1); the value reached before clearing SHALL be latched as line_len.
REQ-012 Within each line, the block SHALL latch the hcnt values at hsync_in rise (hs_on) and fall (hs_off); a line with no hsync rise SHALL clear h_valid, and a complete line SHALL set it.
REQ-013 When h_valid=1, hsync_out SHALL assert at hcnt == (hs_on - hshift_r) mod line_len and deassert at hcnt == (hs_off - hshift_r) mod line_len, using the previous line's latched values; the sync pulse width is therefore preserved.
REQ-014 The line counter vcnt SHALL increment on each hblank_in rise and clear on the hblank_in rise that follows a vblank_in rise; the value reached before clearing SHALL be latched as frame_len. vs_on/vs_off and v_valid SHALL follow the same rules as REQ-012, in lines.
REQ-015 When v_valid=1, vsync_out SHALL change only on hblank_out rise: it asserts at line (vs_on - vshift_r) mod frame_len and deasserts at line (vs_off - vshift_r) mod frame_len.
REQ-016 hshift_r and vshift_r SHALL be sampled from hshift and vshift only on vblank_in rise, so a frame is never torn.
REQ-017 If h_valid=0, hsync_out SHALL be hsync_in delayed one tick; if v_valid=0, vsync_out SHALL be vsync_in delayed one tick.
REQ-018 With shifts of 0, every output SHALL be bit-identical to its input delayed one tick.
REQ-019 Modulo arithmetic SHALL use HW+1 / VW+1 signed intermediates; a result below 0 SHALL add line_len (or frame_len), and a result at or above it SHALL subtract it.
REQ-020 If line_len or frame_len changes between consecutive measurements, the new value SHALL take effect from the next line or frame without glitching the currently active pulse.

Reset
REQ-021 On reset, all outputs SHALL be 0 except hblank_out and vblank_out, which SHALL be 1.
REQ-022 On reset, counters, latched positions and valid flags SHALL be 0, and hshift_r and vshift_r SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL return the block to pass-through mode (REQ-017) until a full line or frame has been re-measured.

Structure
REQ-024 The shared video package SHALL hold the HW and VW defaults and the signed shift type.
REQ-025 One sub-module, sync_repos, SHALL implement edge latching, the modulo compare and the pulse output; it SHALL be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-026 Standard timing (384-tick line, hsync 39..70 ticks after hblank rise, 263-line frame, vsync lines 28..35 after vblank rise), shifts 0 -> outputs equal inputs delayed one ce tick for 3 frames.
REQ-027 hshift=+3 -> from the second line on, hsync_out rises 36 ticks after hblank_out rise and stays high for 31 ticks.
REQ-028 vshift=-2 applied mid-frame -> unchanged until the next vblank rise; then vsync_out asserts at line 30 and deasserts at line 37.
REQ-029 Synthetic hsync at tick 2 with hshift=+5 and line_len 384 -> hsync_out asserts at hcnt 381 of the previous line, with width preserved.
REQ-030 hsync_in held low for one line -> h_valid clears and hsync_out follows the delayed input; after the next complete line, shifting resumes.
REQ-031 Reset pulsed at line 100 -> outputs take their reset values (REQ-021) the next cycle, then pass-through until re-measured; ce_pix=0 for 5 cycles -> no output change.

Source files
------------

// File: rtl/video_pos_adj_pkg.sv
// Shared video definitions: default counter widths and the signed picture-shift type.
package video_pos_adj_pkg;

  localparam int unsigned HwDefault = 9;
  localparam int unsigned VwDefault = 9;

  // Picture offset, -8..+7; positive moves the picture right/down
  typedef logic signed [3:0] shift_t;

endpackage

// File: rtl/sync_repos.sv
// Measures a sync pulse's edge positions per period and regenerates it at a shifted position,
// falling back to the delayed input until a complete period has been measured.
module sync_repos
  import video_pos_adj_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         step,
  input  logic         period_end,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] len,
  input  shift_t       shift,
  input  logic         sync_in,
  output logic         sync_out
);

  logic         sync_q;
  logic         out_q, out_d;
  logic         started_q, valid_q;
  logic         seen_on_q, seen_off_q;
  logic [W-1:0] on_w_q, off_w_q;
  logic [W-1:0] on_r_q, off_r_q;
  logic [W-1:0] on_pos, off_pos;
  logic         rise, fall;

  // (pos - sh) mod period; one correction suffices because |sh| <= 8
  function automatic logic [W-1:0] wrap_pos(input logic [W-1:0] pos, input shift_t sh,
                                            input logic [W-1:0] period);
    logic signed [W:0] d;
    logic signed [W:0] p;
    p = $signed({1'b0, period});
    d = $signed({1'b0, pos}) - $signed({{(W-3){sh[3]}}, sh});
    if (d[W]) begin
      d = d + p;
    end else if (d >= p) begin
      d = d - p;
    end
    return d[W-1:0];
  endfunction

  always_comb begin
    rise    = sync_in & ~sync_q;
    fall    = ~sync_in & sync_q;
    on_pos  = wrap_pos(on_r_q, shift, len);
    off_pos = wrap_pos(off_r_q, shift, len);
    out_d   = out_q;
    if (!valid_q) begin
      out_d = sync_in;
    end else if (step && (cnt == on_pos)) begin
      out_d = 1'b1;
    end else if (step && (cnt == off_pos)) begin
      out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 1'b0;
      out_q      <= 1'b0;
      started_q  <= 1'b0;
      valid_q    <= 1'b0;
      seen_on_q  <= 1'b0;
      seen_off_q <= 1'b0;
      on_w_q     <= '0;
      off_w_q    <= '0;
      on_r_q     <= '0;
      off_r_q    <= '0;
    end else if (ce) begin
      sync_q <= sync_in;
      out_q  <= out_d;
      if (period_end) begin
        // A period only counts once we have seen its start, so a partial one never validates
        started_q  <= 1'b1;
        valid_q    <= started_q & seen_on_q & seen_off_q;
        on_r_q     <= on_w_q;
        off_r_q    <= off_w_q;
        seen_on_q  <= rise;
        seen_off_q <= fall;
      end else begin
        if (rise) seen_on_q <= 1'b1;
        if (fall) seen_off_q <= 1'b1;
      end
      if (rise) on_w_q <= cnt;
      if (fall) off_w_q <= cnt;
    end
  end

  assign sync_out = out_q;

endmodule

// File: rtl/video_pos_adj.sv
// Shifts the sync pulses of a video stream so the picture moves by a signed offset,
// with all outputs delayed one pixel tick.
module video_pos_adj
  import video_pos_adj_pkg::*;
#(
  parameter int unsigned HW = HwDefault,
  parameter int unsigned VW = VwDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  shift_t      hshift,
  input  shift_t      vshift,
  input  logic [11:0] rgb_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] rgb_out,
  output logic        hblank_out,
  output logic        vblank_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic [11:0]   rgb_q;
  logic          hblank_q, vblank_q;
  logic [HW-1:0] hcnt_q, hcnt_d, line_len_q;
  logic [VW-1:0] vcnt_q, vcnt_d, frame_len_q;
  logic          vpend_q, vpend_d;
  shift_t        hshift_q, vshift_q;
  logic          hblank_rise, vblank_rise, frame_start;

  always_comb begin
    hblank_rise = hblank_in & ~hblank_q;
    vblank_rise = vblank_in & ~vblank_q;
    // The frame restarts on the first line start at or after the vblank rise
    frame_start = hblank_rise & (vblank_rise | vpend_q);
    hcnt_d      = hblank_rise ? '0 : hcnt_q + 1'b1;
    vcnt_d      = vcnt_q;
    if (frame_start) begin
      vcnt_d = '0;
    end else if (hblank_rise) begin
      vcnt_d = vcnt_q + 1'b1;
    end
    vpend_d = hblank_rise ? 1'b0 : (vpend_q | vblank_rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= '0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      hcnt_q      <= '0;
      line_len_q  <= '0;
      vcnt_q      <= '0;
      frame_len_q <= '0;
      vpend_q     <= 1'b0;
      hshift_q    <= '0;
      vshift_q    <= '0;
    end else if (ce_pix) begin
      rgb_q    <= rgb_in;
      hblank_q <= hblank_in;
      vblank_q <= vblank_in;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      vpend_q  <= vpend_d;
      if (hblank_rise) line_len_q <= hcnt_q + 1'b1;
      if (frame_start) frame_len_q <= vcnt_q + 1'b1;
      // Shifts change only at a frame boundary so a frame is never torn
      if (vblank_rise) begin
        hshift_q <= hshift;
        vshift_q <= vshift;
      end
    end
  end

  sync_repos #(
    .W (HW)
  ) u_hsync (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce_pix),
    .step       (1'b1),
    .period_end (hblank_rise),
    .cnt        (hcnt_d),
    .len        (line_len_q),
    .shift      (hshift_q),
    .sync_in    (hsync_in),
    .sync_out   (hsync_out)
  );

  sync_repos #(
    .W (VW)
  ) u_vsync (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce_pix),
    .step       (hblank_rise),
    .period_end (frame_start),
    .cnt        (vcnt_d),
    .len        (frame_len_q),
    .shift      (vshift_q),
    .sync_in    (vsync_in),
    .sync_out   (vsync_out)
  );

  assign rgb_out    = rgb_q;
  assign hblank_out = hblank_q;
  assign vblank_out = vblank_q;

endmodule

// File: tb/tb_video_pos_adj.sv
// Directed bench for video_pos_adj: a 384-tick, 40-line timing generator, a table of shift
// configurations checked one per frame, and hand sequences for lost sync, reset and ce gaps.
module tb_video_pos_adj;
  import video_pos_adj_pkg::*;

  // Frame is shortened to 40 lines to keep the run short; sync positions are standard
  localparam int LineLen    = 384;
  localparam int FrameLines = 40;
  localparam int HbLen      = 64;
  localparam int VbLines    = 38;
  localparam int VsOn       = 28;
  localparam int VsOff      = 35;

  logic        clk = 1'b0;
  logic        reset, ce_pix;
  shift_t      hshift, vshift;
  logic [11:0] rgb_in, rgb_out;
  logic        hblank_in, vblank_in, hsync_in, vsync_in;
  logic        hblank_out, vblank_out, hsync_out, vsync_out;

  always #5 clk = ~clk;

  video_pos_adj #(
    .HW (9),
    .VW (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .hshift     (hshift),
    .vshift     (vshift),
    .rgb_in     (rgb_in),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rgb_out    (rgb_out),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  typedef struct {
    shift_t hs;
    shift_t vs;
    int     g_on;
    int     g_off;
    bit     full;
    int     h_on;
    int     h_off;
    int     v_on;
    int     v_off;
  } vec_t;

  vec_t tbl [4];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   line, idx;
  int   g_on, g_off;
  bit   g_hs_en;
  bit   chk_en, chk_sync;
  int   bad_d, bad_s;
  int   h_rise, h_fall, v_rise, v_fall, v_rise_i, v_fall_i;
  logic hs_prev, vs_prev;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive_gen();
    hblank_in = (idx < HbLen);
    vblank_in = (line < VbLines);
    hsync_in  = g_hs_en && (idx >= g_on) && (idx < g_off);
    vsync_in  = (line >= VsOn) && (line < VsOff);
    rgb_in    = 12'((idx * 7 + line * 131) ^ 'h5a3);
  endtask

  // One pixel tick: drive, clock, then compare against what was driven and log sync edges
  task automatic tick();
    logic [13:0] e_d;
    logic [1:0]  e_s;
    drive_gen();
    e_d = {rgb_in, hblank_in, vblank_in};
    e_s = {hsync_in, vsync_in};
    @(posedge clk);
    #1;
    if ({rgb_out, hblank_out, vblank_out} !== e_d) bad_d++;
    if ({hsync_out, vsync_out} !== e_s) bad_s++;
    if (hsync_out && !hs_prev) h_rise = idx;
    if (!hsync_out && hs_prev) h_fall = idx;
    if (vsync_out && !vs_prev) begin
      v_rise   = line;
      v_rise_i = idx;
    end
    if (!vsync_out && vs_prev) begin
      v_fall   = line;
      v_fall_i = idx;
    end
    hs_prev = hsync_out;
    vs_prev = vsync_out;
    idx++;
    if (idx == LineLen) begin
      idx = 0;
      line++;
      if (line == FrameLines) line = 0;
    end
  endtask

  task automatic ce_gap();
    logic [15:0] snap;
    snap   = {rgb_out, hblank_out, vblank_out, hsync_out, vsync_out};
    ce_pix = 1'b0;
    repeat (5) begin
      rgb_in    = 12'($urandom);
      hblank_in = 1'($urandom);
      vblank_in = 1'($urandom);
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      @(posedge clk);
      #1;
      check("ce_hold", int'({rgb_out, hblank_out, vblank_out, hsync_out, vsync_out}),
            int'(snap));
    end
    ce_pix = 1'b1;
  endtask

  task automatic run_line(input int gap_at);
    int l;
    l      = line;
    bad_d  = 0;
    bad_s  = 0;
    h_rise = -1;
    h_fall = -1;
    if (line == 0) begin
      v_rise   = -1;
      v_fall   = -1;
      v_rise_i = -1;
      v_fall_i = -1;
    end
    for (int i = 0; i < LineLen; i++) begin
      if (i == gap_at) ce_gap();
      tick();
    end
    if (chk_en) begin
      check($sformatf("delay_L%0d bad ticks", l), bad_d, 0);
      if (chk_sync) check($sformatf("sync_L%0d bad ticks", l), bad_s, 0);
    end
  endtask

  initial begin
    tbl[0] = '{shift_t'(0), shift_t'(0), 39, 70, 1'b1, 39, 70, 28, 35};
    tbl[1] = '{shift_t'(5), shift_t'(0), 2, 33, 1'b0, 381, 28, 28, 35};
    tbl[2] = '{shift_t'(3), shift_t'(-2), 39, 70, 1'b0, 36, 67, 30, 37};
    tbl[3] = '{shift_t'(-8), shift_t'(7), 378, 383, 1'b0, 2, 7, 21, 28};

    reset    = 1'b1;
    ce_pix   = 1'b1;
    hshift   = shift_t'(0);
    vshift   = shift_t'(0);
    g_on     = 39;
    g_off    = 70;
    g_hs_en  = 1'b1;
    line     = 30;
    idx      = 200;
    chk_en   = 1'b0;
    chk_sync = 1'b1;
    hs_prev  = 1'b0;
    vs_prev  = 1'b0;
    drive_gen();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({rgb_out, hblank_out, vblank_out, hsync_out, vsync_out}),
          32'h000C);
    reset = 1'b0;

    // Start mid-frame; everything must pass straight through while measuring
    while (idx != 0) tick();
    chk_en = 1'b1;
    while (line != 0) run_line(-1);

    for (int e = 0; e < 4; e++) begin
      g_on     = tbl[e].g_on;
      g_off    = tbl[e].g_off;
      chk_sync = tbl[e].full;
      for (int l = 0; l < FrameLines; l++) begin
        // Next entry's shifts arrive mid-frame and must not act before the next vblank
        if (l == 10 && e < 3) begin
          hshift = tbl[e+1].hs;
          vshift = tbl[e+1].vs;
        end
        run_line(-1);
        if (l == 5) begin
          check($sformatf("E%0d hsync_on", e), h_rise, tbl[e].h_on);
          check($sformatf("E%0d hsync_off", e), h_fall, tbl[e].h_off);
        end
      end
      check($sformatf("E%0d vsync_on_line", e), v_rise, tbl[e].v_on);
      check($sformatf("E%0d vsync_off_line", e), v_fall, tbl[e].v_off);
      check($sformatf("E%0d vsync_on_tick", e), v_rise_i, 0);
      check($sformatf("E%0d vsync_off_tick", e), v_fall_i, 0);
    end

    // Lost hsync for one line with hshift -8 latched
    chk_sync = 1'b0;
    g_on     = 39;
    g_off    = 70;
    run_line(-1);
    run_line(-1);
    g_hs_en = 1'b0;
    run_line(-1);
    check("miss_line hsync_on", h_rise, 47);
    check("miss_line hsync_off", h_fall, 78);
    g_hs_en = 1'b1;
    run_line(-1);
    check("after_miss hsync_on", h_rise, 39);
    check("after_miss hsync_off", h_fall, 70);
    run_line(-1);
    check("resume hsync_on", h_rise, 47);
    check("resume hsync_off", h_fall, 78);
    run_line(-1);

    // Mid-frame reset: outputs reset next cycle, then pass-through with shifts cleared
    chk_en = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    check("reset_mid_outputs", int'({rgb_out, hblank_out, vblank_out, hsync_out, vsync_out}),
          32'h000C);
    reset = 1'b0;
    while (idx != 0) tick();
    chk_en   = 1'b1;
    chk_sync = 1'b1;
    run_line(-1);
    run_line(-1);
    run_line(50);
    run_line(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
